// File: rtl/cu_id.sv
// RV32I decode stage with a one-entry skid buffer so ID_ready is a registered output.
// Optional ID_RV32M_EN accepts R-type funct7=0000001 (RV32M) as legal.
module cu_id #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            soc_clk,
    input  logic            ID_reset,
    input  logic            ID_stall,
    input  logic            ID_flush,
    input  logic            IF_valid,
    input  logic [31:0]     IF_data,
    input  logic [PC_W-1:0] IF_pc,
    output logic            ID_ready,
    output logic            ID_valid,
    output logic [PC_W-1:0] ID_pc,
    output logic [6:0]      ID_opcode,
    output logic [4:0]      ID_rd,
    output logic [2:0]      ID_funct3,
    output logic [4:0]      ID_rs1,
    output logic [4:0]      ID_rs2,
    output logic [6:0]      ID_funct7,
    output logic [31:0]     ID_imm,
    output logic [2:0]      ID_instr_type,
    output logic            ID_illegal
);

    localparam logic [2:0] T_R   = 3'd0;
    localparam logic [2:0] T_I   = 3'd1;
    localparam logic [2:0] T_S   = 3'd2;
    localparam logic [2:0] T_B   = 3'd3;
    localparam logic [2:0] T_U   = 3'd4;
    localparam logic [2:0] T_J   = 3'd5;
    localparam logic [2:0] T_ILL = 3'd7;

    typedef struct packed {
        logic [2:0]  ty;
        logic        ill;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] i);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        f3    = i[14:12];
        f7    = i[31:25];
        d.ty  = T_ILL;
        d.imm = '0;
        ok    = 1'b1;
        unique case (i[6:0])
            7'b0110011: begin
                ok = (f7 == 7'h00)
                   || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
`ifdef ID_RV32M_EN
                if (f7 == 7'h01) ok = 1'b1;
`endif
                d.ty = T_R;
            end
            7'b0010011: begin
                if (f3 == 3'b001) ok = (f7 == 7'h00);
                if (f3 == 3'b101) ok = (f7 == 7'h00 || f7 == 7'h20);
                d.ty  = T_I;
                d.imm = {{20{i[31]}}, i[31:20]};
            end
            7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                d.ty  = T_I;
                d.imm = {{20{i[31]}}, i[31:20]};
            end
            7'b0100011: begin
                d.ty  = T_S;
                d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            7'b1100011: begin
                d.ty  = T_B;
                d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                d.ty  = T_U;
                d.imm = {i[31:12], 12'b0};
            end
            7'b1101111: begin
                d.ty  = T_J;
                d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            default: ok = 1'b0;
        endcase
        d.ill = ~ok;
        if (!ok) begin
            d.ty  = T_ILL;
            d.imm = '0;
        end
        return d;
    endfunction

    logic            skid_valid;
    logic [31:0]     skid_data;
    logic [PC_W-1:0] skid_pc;
    logic [31:0]     src_data;
    logic [PC_W-1:0] src_pc;
    dec_t            src_dec;
    logic            accept;
    logic            drain;

    assign ID_ready = ~skid_valid;
    assign accept   = IF_valid & ID_ready;
    assign drain    = ID_valid & ~ID_stall;

    // SKID is always older than IF, so it wins the OUT slot when occupied
    always_comb begin
        src_data = skid_valid ? skid_data : IF_data;
        src_pc   = skid_valid ? skid_pc : IF_pc;
        src_dec  = decode(src_data);
    end

    always_ff @(posedge soc_clk) begin
        if (ID_reset) begin
            ID_valid      <= 1'b0;
            ID_pc         <= RESET_PC;
            ID_opcode     <= '0;
            ID_rd         <= '0;
            ID_funct3     <= '0;
            ID_rs1        <= '0;
            ID_rs2        <= '0;
            ID_funct7     <= '0;
            ID_imm        <= '0;
            ID_instr_type <= '0;
            ID_illegal    <= 1'b0;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            skid_pc       <= '0;
        end else if (ID_flush) begin
            ID_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!ID_valid || drain) begin
            if (skid_valid || IF_valid) begin
                ID_valid      <= 1'b1;
                ID_pc         <= src_pc;
                ID_opcode     <= src_data[6:0];
                ID_rd         <= src_data[11:7];
                ID_funct3     <= src_data[14:12];
                ID_rs1        <= src_data[19:15];
                ID_rs2        <= src_data[24:20];
                ID_funct7     <= src_data[31:25];
                ID_imm        <= src_dec.imm;
                ID_instr_type <= src_dec.ty;
                ID_illegal    <= src_dec.ill;
                skid_valid    <= 1'b0;
            end else begin
                ID_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= IF_data;
            skid_pc    <= IF_pc;
        end
    end

endmodule
